stream_demux_1_4: RTL and testbench
===================================

# stream_demux_1_4

Four-way stream demultiplexer: the distributing counterpart of our 4:1 gate-level mux. One valid/ready input stream carries a data word plus a 2-bit destination select; each accepted word is routed into a small per-destination FIFO and presented on that destination's valid/ready output port. It sits between a single producer and four independent consumers, so a stalled consumer blocks only traffic addressed to it.

## Interface
- `WIDTH`, 4, data word width in bits
- `DEPTH`, 2, entries per output FIFO; power of two, ≥ 2
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  synchronous, active-low reset
- `in_valid`  input  1  producer word valid
- `in_ready`  output  1  block accepts word this cycle
- `in_sel`  input  2  destination index 0..3, qualified by `in_valid`
- `in_data`  input  WIDTH  producer word
- `out_valid`  output  4  bit i: output i has a word
- `out_ready`  input  4  bit i: consumer i takes word
- `d0`, `d1`, `d2`, `d3`  output  WIDTH each  head word of output FIFO 0..3

## Operation
- Input transfer occurs when `in_valid & in_ready`; word is pushed into FIFO `in_sel` only.
- `in_ready = ~full[in_sel]`; combinational from `in_sel` and registered FIFO state only, never from `out_ready` (no full-and-pop pass-through).
- `in_ready` is driven regardless of `in_valid`; the producer must hold `in_sel`/`in_data` stable while `in_valid` is high and not accepted.
- Output transfer on port i occurs when `out_valid[i] & out_ready[i]`; pops FIFO i head.
- `out_valid[i] = ~empty[i]`; `d<i>` = head entry of FIFO i (registered storage, no combinational path from `in_data`).
- Each FIFO: write pointer, read pointer, occupancy count 0..DEPTH, log2(DEPTH)-bit pointers wrap from DEPTH-1 to 0.
- Push and pop on same FIFO same cycle: allowed when count ≥ 1 and < DEPTH; count unchanged, both pointers advance.
- Push to empty FIFO while `out_ready` high: no pop that cycle (FIFO was empty); word appears next cycle.
- Order preserved per destination; no ordering relation between destinations.
- Four outputs drain independently and concurrently.
- `out_ready[i]` with `out_valid[i]` low: ignored.

## Timing
- Reset (`rst` low at rising edge): all counts 0, pointers 0, storage 0 → `out_valid = 4'b0000`, `d0..d3 = 0`, `in_ready = 1`.
- Reset mid-operation: all buffered words discarded; next cycle state equals post-reset state.
- Input-to-output latency: 1 cycle (word accepted at edge N visible with `out_valid` at cycle N+1).
- Throughput: one input word per cycle while the selected FIFO is not full; each output sustains one word per cycle.
- Full FIFO i: `in_ready` low whenever `in_sel == i`; rises the cycle after a pop of FIFO i.

## Structure
- Package `stream_demux_pkg`: `NUM_OUT = 4`, `typedef logic [1:0] sel_t`.
- Sub-module `demux_out_fifo` (parameters `WIDTH`, `DEPTH`; ports `clk`, `rst`, `push`, `wdata`, `pop`, `rdata`, `empty`, `full`), instantiated four times; top level holds only select decode, `in_ready` mux and per-FIFO push/pop generation.
- Select decode written with `&`, `|`, `~` over `in_sel` bits, matching our mux style.

## Test plan
- Reset then idle: `rst` low 2 cycles → `out_valid = 0`, `d0..d3 = 0`, `in_ready = 1`.
- Send 4'hA sel 0, 4'hB sel 1, 4'hC sel 2, 4'hD sel 3 back-to-back, all `out_ready = 1` → each `d<i>` shows its word exactly 1 cycle after acceptance, `out_valid` one-hot pulses.
- `out_ready[2] = 0`, send 3 words to sel 2 (DEPTH 2) → first two accepted, `in_ready` low on third; meanwhile a word to sel 0 is accepted and delivered; raise `out_ready[2]` → 4'h1, 4'h2, then third word in order.
- FIFO 1 holding 1 word, simultaneous push and pop every cycle for 8 cycles → count stays 1, pointers wrap, data order exact.
- Fill FIFO 3 with 2 words, assert `rst` low one cycle → `out_valid = 0`, `in_ready = 1`, old words never appear.
- Randomised `in_sel`/`out_ready` backpressure, 1000 words → per-destination scoreboard matches, no loss, no duplication.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
package stream_demux_pkg;
  localparam int NUM_OUT = 4;
  typedef logic [1:0] sel_t;
endpackage

// File: rtl/demux_out_fifo.sv
// Small per-destination FIFO: register storage, head word always visible on rdata.
module demux_out_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wptr_reg;
  logic [PW-1:0]    rptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Guard against over/underflow even if the caller misbehaves.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign rdata   = mem_reg[rptr_reg];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      for (int k = 0; k < DEPTH; k++) mem_reg[k] <= '0;
    end else begin
      if (push_ok) begin
        mem_reg[wptr_reg] <= wdata;
        wptr_reg          <= wptr_reg + 1'b1;
      end
      if (pop_ok) rptr_reg <= rptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/stream_demux_1_4.sv
// One valid/ready input routed by in_sel into four independently drained output FIFOs.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3
);
  sel_t                sel;
  logic [NUM_OUT-1:0]  sel_dec;
  logic [NUM_OUT-1:0]  push;
  logic [NUM_OUT-1:0]  pop;
  logic [NUM_OUT-1:0]  empty;
  logic [NUM_OUT-1:0]  full;
  logic [WIDTH-1:0]    head [NUM_OUT];

  assign sel = in_sel;

  // Gate-level decode, same shape as the 4:1 mux select logic.
  assign sel_dec[0] = ~sel[1] & ~sel[0];
  assign sel_dec[1] = ~sel[1] &  sel[0];
  assign sel_dec[2] =  sel[1] & ~sel[0];
  assign sel_dec[3] =  sel[1] &  sel[0];

  // Ready depends only on the selected FIFO's registered fullness, never on out_ready.
  assign in_ready = |(sel_dec & ~full);

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
      assign push[gi]      = in_valid & sel_dec[gi] & ~full[gi];
      assign pop[gi]       = out_ready[gi] & ~empty[gi];
      assign out_valid[gi] = ~empty[gi];

      demux_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[gi]),
        .wdata (in_data),
        .pop   (pop[gi]),
        .rdata (head[gi]),
        .empty (empty[gi]),
        .full  (full[gi])
      );
    end
  endgenerate

  assign d0 = head[0];
  assign d1 = head[1];
  assign d2 = head[2];
  assign d3 = head[3];
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Scoreboard bench for stream_demux_1_4: directed scenarios plus random backpressure.
module tb_stream_demux_1_4;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_sel = 2'd0;
  logic [3:0] in_data = 4'h0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'h0;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] dv [4];

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q [4][$];

  always #5 clk = ~clk;

  stream_demux_1_4 #(.WIDTH(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3)
  );

  assign dv[0] = d0;
  assign dv[1] = d1;
  assign dv[2] = d2;
  assign dv[3] = d3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops expected words on every output transfer, records accepted inputs.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            failures++;
            $display("FAIL out%0d_unexpected actual=%0h required=none", i, dv[i]);
          end else begin
            logic [3:0] e;
            e = exp_q[i].pop_front();
            if (dv[i] !== e) begin
              failures++;
              $display("FAIL out%0d_data actual=%0h required=%0h", i, dv[i], e);
            end
            $display("out%0d word=%0h", i, dv[i]);
          end
        end
      end
      if (in_valid && in_ready) exp_q[in_sel].push_back(in_data);
    end
  end

  task automatic send(input logic [1:0] s, input logic [3:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=stalled required=accept sel=%0d", s);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("in sel=%0d word=%0h", s, v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic done = 1'b0;

  initial begin
    // Reset then idle
    idle(2);
    rst = 1'b1;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_d", {16'h0, d3, d2, d1, d0}, 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);

    // Back-to-back to each destination, everything draining
    out_ready = 4'hF;
    send(2'd0, 4'hA);
    check("b2b_valid0", 32'(out_valid), 32'h1);
    check("b2b_d0", 32'(d0), 32'hA);
    send(2'd1, 4'hB);
    check("b2b_valid1", 32'(out_valid), 32'h2);
    check("b2b_d1", 32'(d1), 32'hB);
    send(2'd2, 4'hC);
    check("b2b_valid2", 32'(out_valid), 32'h4);
    check("b2b_d2", 32'(d2), 32'hC);
    send(2'd3, 4'hD);
    check("b2b_valid3", 32'(out_valid), 32'h8);
    check("b2b_d3", 32'(d3), 32'hD);
    idle(1);
    check("b2b_drained", 32'(out_valid), 32'h0);

    // Full FIFO 2 blocks only sel 2
    out_ready = 4'b1011;
    send(2'd2, 4'h1);
    send(2'd2, 4'h2);
    in_sel = 2'd2;
    #1;
    check("full2_in_ready", 32'(in_ready), 32'h0);
    send(2'd0, 4'h5);
    check("other_path_d0", 32'(d0), 32'h5);
    check("other_path_valid", 32'(out_valid), 32'h5);
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 4'h3;
    repeat (2) begin
      @(negedge clk);
      check("full2_hold_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    send(2'd2, 4'h3);
    idle(4);
    check("full2_drained", 32'(out_valid), 32'h0);

    // Simultaneous push and pop on FIFO 1, count held at 1
    out_ready = 4'h0;
    send(2'd1, 4'h0);
    out_ready = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      send(2'd1, 4'(k));
      check("pp_d1", 32'(d1), 32'(k));
      check("pp_in_ready", 32'(in_ready), 32'h1);
    end
    idle(2);
    check("pp_drained", 32'(out_valid), 32'h0);

    // Reset with FIFO 3 full discards its words
    out_ready = 4'h0;
    send(2'd3, 4'hE);
    send(2'd3, 4'hF);
    in_sel = 2'd3;
    #1;
    check("prereset_valid", 32'(out_valid), 32'h8);
    check("prereset_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("midreset_valid", 32'(out_valid), 32'h0);
    check("midreset_in_ready", 32'(in_ready), 32'h1);
    check("midreset_d3", 32'(d3), 32'h0);
    out_ready = 4'hF;
    idle(4);
    check("midreset_stays_empty", 32'(out_valid), 32'h0);

    // Random selects and backpressure
    fork
      begin
        for (int k = 0; k < 1000; k++) send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 4'($urandom_range(0, 15));
        end
      end
    join
    out_ready = 4'hF;
    idle(6);
    for (int i = 0; i < 4; i++) check("final_queue_empty", 32'(exp_q[i].size()), 32'h0);
    check("final_out_valid", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
